// File: rtl/cass_in_conditioner.sv
// Cassette input conditioner: synchronises and de-glitches the tape comparator bit,
// tracks carrier presence to gate CASS_IN, and measures edge-to-edge half-periods.
module cass_in_conditioner #(
  parameter int GLITCH_CYCLES  = 24,
  parameter int MIN_EDGES      = 16,
  parameter int TIMEOUT_CYCLES = 1200000,
  parameter int CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ADC_BIT,
  input  logic             ADC_ACTIVE,
  input  logic             ENABLE,
  output logic             CASS_IN,
  output logic             EDGE,
  output logic [CNT_W-1:0] PERIOD,
  output logic             PERIOD_VALID,
  output logic             CARRIER,
  output logic             LED,
  output logic [1:0]       state_dbg
);

  localparam int GW = $clog2(GLITCH_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int EW = $clog2(MIN_EDGES + 1);

  localparam logic [GW-1:0]    GLITCH_LAST = GW'(GLITCH_CYCLES - 1);
  localparam logic [TW-1:0]    TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]    TMO_MAX     = TW'(TIMEOUT_CYCLES);
  localparam logic [EW-1:0]    EDGE_TARGET = EW'(MIN_EDGES);
  localparam logic [CNT_W-1:0] PER_MAX     = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  logic [1:0]       bit_sync, act_sync;
  logic             bit_s, act_s;
  logic             filt_q, tog_q, differ, toggle_now;
  logic [GW-1:0]    run_q;
  logic [TW-1:0]    tmo_q;
  logic [CNT_W-1:0] per_q;
  logic [EW-1:0]    ecnt_q, ecnt_d;
  state_t           state_q, state_d;
  logic             abort, edge_evt, timeout, meas_ok;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bit_sync <= '0;
      act_sync <= '0;
    end else begin
      bit_sync <= {bit_sync[0], ADC_BIT};
      act_sync <= {act_sync[0], ADC_ACTIVE};
    end
  end

  assign bit_s = bit_sync[1];
  assign act_s = act_sync[1];

  // Run counter tracks how long the synced bit has disagreed with the filtered level.
  assign differ     = (bit_s != filt_q);
  assign toggle_now = differ && (run_q == GLITCH_LAST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      run_q  <= '0;
      filt_q <= 1'b0;
      tog_q  <= 1'b0;
    end else begin
      tog_q <= toggle_now;
      if (!differ || toggle_now) begin
        run_q <= '0;
      end else begin
        run_q <= run_q + GW'(1);
      end
      if (toggle_now) begin
        filt_q <= ~filt_q;
      end
    end
  end

  assign abort    = !act_s || !ENABLE;
  assign edge_evt = tog_q;
  // Fires as the counter steps onto TIMEOUT_CYCLES, so CARRIER drops exactly
  // TIMEOUT_CYCLES cycles after the last EDGE pulse. An edge in the same cycle wins.
  assign timeout  = !edge_evt && (tmo_q >= TMO_LAST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tmo_q <= '0;
      per_q <= '0;
    end else begin
      if (abort || edge_evt) begin
        tmo_q <= '0;
      end else if (tmo_q != TMO_MAX) begin
        tmo_q <= tmo_q + TW'(1);
      end
      if (edge_evt) begin
        per_q <= CNT_W'(1);
      end else if (per_q != PER_MAX) begin
        per_q <= per_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ecnt_q  <= ecnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ecnt_d  = ecnt_q;
    if (abort) begin
      state_d = IDLE;
      ecnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (edge_evt) begin
            ecnt_d  = EW'(1);
            state_d = (MIN_EDGES <= 1) ? LOCKED : ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (edge_evt) begin
            ecnt_d = ecnt_q + EW'(1);
            if ((ecnt_q + EW'(1)) == EDGE_TARGET) begin
              state_d = LOCKED;
            end
          end else if (timeout) begin
            state_d = IDLE;
            ecnt_d  = '0;
          end
        end
        LOCKED: begin
          if (timeout) begin
            state_d = IDLE;
            ecnt_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
          ecnt_d  = '0;
        end
      endcase
    end
  end

  // PERIOD_VALID is a one-cycle strobe with no back-pressure; PERIOD holds its
  // value until the next strobe (carrier loss does not clear it).
  assign meas_ok = edge_evt && !abort && (state_q != IDLE);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      EDGE         <= 1'b0;
      PERIOD_VALID <= 1'b0;
      PERIOD       <= '0;
    end else begin
      EDGE         <= edge_evt && !abort;
      PERIOD_VALID <= meas_ok;
      if (meas_ok) begin
        PERIOD <= per_q;
      end
    end
  end

  assign CARRIER   = (state_q == LOCKED);
  assign CASS_IN   = CARRIER && filt_q;
  assign LED       = CARRIER && filt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cass_in_conditioner.sv
// Bench for cass_in_conditioner: segment-level reference model of the input waveform
// predicts edges, periods, carrier and gated level per cycle.
module tb_cass_in_conditioner;

  localparam int G    = 4;
  localparam int ME   = 4;
  localparam int TO   = 1000;
  localparam int MAXT = 2048;

  logic       CLK = 1'b0;
  logic       RESET_N, ADC_BIT, ADC_ACTIVE, ENABLE;
  logic       CASS_IN, EDGE, PERIOD_VALID, CARRIER, LED;
  logic [15:0] PERIOD;
  logic [1:0] state_dbg;
  logic       cass8, edge8, pv8, car8, led8;
  logic [7:0] per8;
  logic [1:0] state8;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_no  = 0;

  logic seg_lvl[$];
  int   seg_len[$];
  int   edge_at[$];
  logic cur_filt;
  int   exp_t;
  logic exp_edge[MAXT], exp_pv[MAXT], exp_car[MAXT], exp_cass[MAXT];
  int   exp_per[MAXT];
  logic obs_edge[MAXT], obs_pv[MAXT], obs_car[MAXT], obs_cass[MAXT], obs_led[MAXT];
  logic obs_pv8[MAXT];
  logic [15:0] obs_per[MAXT];
  logic [7:0]  obs_per8[MAXT];
  int   last_edge_abs;

  cass_in_conditioner #(.GLITCH_CYCLES(G), .MIN_EDGES(ME), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ADC_BIT(ADC_BIT), .ADC_ACTIVE(ADC_ACTIVE), .ENABLE(ENABLE),
    .CASS_IN(CASS_IN), .EDGE(EDGE), .PERIOD(PERIOD), .PERIOD_VALID(PERIOD_VALID),
    .CARRIER(CARRIER), .LED(LED), .state_dbg(state_dbg)
  );

  cass_in_conditioner #(.GLITCH_CYCLES(G), .MIN_EDGES(ME), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut8 (
    .CLK(CLK), .RESET_N(RESET_N), .ADC_BIT(ADC_BIT), .ADC_ACTIVE(ADC_ACTIVE), .ENABLE(ENABLE),
    .CASS_IN(cass8), .EDGE(edge8), .PERIOD(per8), .PERIOD_VALID(pv8),
    .CARRIER(car8), .LED(led8), .state_dbg(state8)
  );

  // Clock / reset block
  always #5 CLK = ~CLK;

  initial begin
    #10000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
    tick_no++;
  endtask

  task automatic go_idle();
    ENABLE = 1'b0;
    tick();
    tick();
    ENABLE = 1'b1;
    tick();
  endtask

  task automatic alt_segs(input int n, input int lo, input int hi);
    logic l;
    seg_lvl.delete();
    seg_len.delete();
    l = ~cur_filt;
    for (int i = 0; i < n; i++) begin
      seg_lvl.push_back(l);
      seg_len.push_back(int'($urandom_range(hi, lo)));
      l = ~l;
    end
  endtask

  // Reference model: a level held for G or more cycles against the filtered level is
  // accepted; filtered level flips 2+G-1 cycles in, EDGE shows one cycle later.
  function automatic void build_model();
    int   t;
    int   ne;
    logic f, fp;
    int   tog_t[$];
    logic tog_l[$];
    t = 0;
    f = cur_filt;
    edge_at.delete();
    for (int i = 0; i < seg_len.size(); i++) begin
      if (seg_lvl[i] != f && seg_len[i] >= G) begin
        tog_t.push_back(t + G + 1);
        tog_l.push_back(seg_lvl[i]);
        edge_at.push_back(t + G + 2);
        f = seg_lvl[i];
      end
      t += seg_len[i];
    end
    seg_lvl.push_back(f);
    seg_len.push_back(10);
    t += 10;
    exp_t = t;
    for (int p = 0; p < t; p++) begin
      exp_edge[p] = 1'b0;
      exp_pv[p]   = 1'b0;
      exp_per[p]  = 0;
      ne = 0;
      foreach (edge_at[k]) if (edge_at[k] <= p) ne++;
      fp = cur_filt;
      foreach (tog_t[k]) if (tog_t[k] <= p) fp = tog_l[k];
      exp_car[p]  = (ne >= ME);
      exp_cass[p] = exp_car[p] & fp;
    end
    foreach (edge_at[k]) begin
      exp_edge[edge_at[k]] = 1'b1;
      if (k > 0) begin
        exp_pv[edge_at[k]]  = 1'b1;
        exp_per[edge_at[k]] = edge_at[k] - edge_at[k-1];
      end
    end
    cur_filt = f;
  endfunction

  task automatic play();
    int p;
    build_model();
    p = 0;
    for (int i = 0; i < seg_len.size(); i++) begin
      for (int j = 0; j < seg_len[i]; j++) begin
        ADC_BIT = seg_lvl[i];
        tick();
        obs_edge[p] = EDGE;
        obs_pv[p]   = PERIOD_VALID;
        obs_car[p]  = CARRIER;
        obs_cass[p] = CASS_IN;
        obs_led[p]  = LED;
        obs_per[p]  = PERIOD;
        obs_pv8[p]  = pv8;
        obs_per8[p] = per8;
        p++;
      end
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    RESET_N = 1'b0; ADC_BIT = 1'b0; ADC_ACTIVE = 1'b0; ENABLE = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if ({CASS_IN, EDGE, PERIOD_VALID, CARRIER, LED} !== 5'b0 || PERIOD !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got flags=%b period=%0d expected 0/0",
               {CASS_IN, EDGE, PERIOD_VALID, CARRIER, LED}, PERIOD);
    end
    n_checks++;
    if (state_dbg !== 2'd0 || state8 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state got %0d/%0d expected 0", state_dbg, state8);
    end
    n_checks++;
    if ({cass8, edge8, pv8, car8, led8} !== 5'b0 || per8 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs8 got flags=%b period=%0d expected 0/0",
               {cass8, edge8, pv8, car8, led8}, per8);
    end
    RESET_N = 1'b1; ADC_ACTIVE = 1'b1; ENABLE = 1'b1;
    repeat (5) tick();
    cur_filt = 1'b0;
  endtask

  task automatic test_glitch();
    int n_edge, first_p;
    n_edge = 0;
    for (int p = 0; p < 15; p++) begin
      ADC_BIT = (p < 3);
      tick();
      if (EDGE === 1'b1) n_edge++;
    end
    n_checks++;
    if (n_edge !== 0 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL glitch_3cyc got edges=%0d state=%0d expected 0/0", n_edge, state_dbg);
    end
    n_edge = 0;
    first_p = -1;
    for (int p = 0; p < 10; p++) begin
      ADC_BIT = (p < 4);
      tick();
      if (EDGE === 1'b1) begin
        n_edge++;
        if (first_p < 0) first_p = p;
      end
    end
    n_checks++;
    if (n_edge !== 1) begin
      n_fail++;
      $display("FAIL glitch_4cyc_count got %0d expected 1", n_edge);
    end
    n_checks++;
    if (first_p !== G + 2) begin
      n_fail++;
      $display("FAIL glitch_4cyc_latency got cycle %0d expected %0d", first_p + 1, G + 3);
    end
    ADC_BIT = 1'b0;
    tick();
    n_checks++;
    if (EDGE !== 1'b1 || PERIOD_VALID !== 1'b1 || PERIOD !== 16'd4) begin
      n_fail++;
      $display("FAIL glitch_fall got edge=%b pv=%b period=%0d expected 1/1/4", EDGE, PERIOD_VALID, PERIOD);
    end
    go_idle();
    cur_filt = 1'b0;
  endtask

  task automatic test_lock();
    logic [4:0] ev, ov;
    int start;
    alt_segs(6, 100, 100);
    start = tick_no;
    play();
    for (int p = 0; p < exp_t; p++) begin
      ev = {exp_edge[p], exp_pv[p], exp_car[p], exp_cass[p], exp_cass[p]};
      ov = {obs_edge[p], obs_pv[p], obs_car[p], obs_cass[p], obs_led[p]};
      n_checks++;
      if (ov !== ev) begin
        n_fail++;
        $display("FAIL lock_flags t=%0d edge/pv/car/cass/led got %b expected %b", p, ov, ev);
      end
      if (exp_pv[p]) begin
        n_checks++;
        if (obs_per[p] !== 16'(exp_per[p])) begin
          n_fail++;
          $display("FAIL lock_period t=%0d got %0d expected %0d", p, obs_per[p], exp_per[p]);
        end
      end
    end
    n_checks++;
    if (obs_car[305] !== 1'b0 || obs_car[306] !== 1'b1 || obs_per[306] !== 16'd100) begin
      n_fail++;
      $display("FAIL lock_4th_edge got car=%b%b period=%0d expected 01/100",
               obs_car[305], obs_car[306], obs_per[306]);
    end
    last_edge_abs = start + 1 + edge_at[edge_at.size()-1];
  endtask

  task automatic test_timeout();
    logic fell;
    int   dt;
    fell = 1'b0;
    for (int i = 0; i < 1500 && !fell; i++) begin
      tick();
      if (CARRIER === 1'b0) fell = 1'b1;
    end
    dt = tick_no - last_edge_abs;
    n_checks++;
    if (!fell || dt !== TO) begin
      n_fail++;
      $display("FAIL timeout_delay got fell=%b after %0d cycles expected %0d", fell, dt, TO);
    end
    n_checks++;
    if (CASS_IN !== 1'b0 || LED !== 1'b0 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL timeout_idle got cass=%b led=%b state=%0d expected 0/0/0", CASS_IN, LED, state_dbg);
    end
    n_checks++;
    if (PERIOD !== 16'd100) begin
      n_fail++;
      $display("FAIL timeout_period_hold got %0d expected 100", PERIOD);
    end
  endtask

  task automatic test_abort();
    logic [4:0] ev, ov;
    alt_segs(4, 50, 50);
    play();
    n_checks++;
    if (obs_car[exp_t-1] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_prelock got carrier=%b expected 1", obs_car[exp_t-1]);
    end
    ADC_ACTIVE = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (CARRIER !== 1'b0 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL abort_drop got carrier=%b state=%0d expected 0/0", CARRIER, state_dbg);
    end
    alt_segs(4, 20, 20);
    play();
    for (int p = 0; p < exp_t; p++) begin
      n_checks++;
      if ({obs_edge[p], obs_pv[p], obs_car[p]} !== 3'b000) begin
        n_fail++;
        $display("FAIL abort_suppress t=%0d edge/pv/car got %b expected 000",
                 p, {obs_edge[p], obs_pv[p], obs_car[p]});
      end
    end
    ADC_ACTIVE = 1'b1;
    repeat (4) tick();
    alt_segs(4, 30, 30);
    play();
    for (int p = 0; p < exp_t; p++) begin
      ev = {exp_edge[p], exp_pv[p], exp_car[p], exp_cass[p], exp_cass[p]};
      ov = {obs_edge[p], obs_pv[p], obs_car[p], obs_cass[p], obs_led[p]};
      n_checks++;
      if (ov !== ev) begin
        n_fail++;
        $display("FAIL abort_relock t=%0d edge/pv/car/cass/led got %b expected %b", p, ov, ev);
      end
      if (exp_pv[p]) begin
        n_checks++;
        if (obs_per[p] !== 16'(exp_per[p])) begin
          n_fail++;
          $display("FAIL abort_period t=%0d got %0d expected %0d", p, obs_per[p], exp_per[p]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int p;
    go_idle();
    alt_segs(3, 300, 300);
    play();
    foreach (edge_at[k]) begin
      p = edge_at[k];
      n_checks++;
      if (obs_pv8[p] !== exp_pv[p]) begin
        n_fail++;
        $display("FAIL sat_valid edge=%0d got %b expected %b", k, obs_pv8[p], exp_pv[p]);
      end
      if (exp_pv[p]) begin
        n_checks++;
        if (obs_per8[p] !== 8'((exp_per[p] > 255) ? 255 : exp_per[p]) || obs_per[p] !== 16'(exp_per[p])) begin
          n_fail++;
          $display("FAIL sat_period edge=%0d got %0d/%0d expected %0d/%0d", k, obs_per8[p], obs_per[p],
                   (exp_per[p] > 255) ? 255 : exp_per[p], exp_per[p]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] ev, ov;
    for (int r = 0; r < 3; r++) begin
      go_idle();
      alt_segs(40, 1, 20);
      play();
      for (int p = 0; p < exp_t; p++) begin
        ev = {exp_edge[p], exp_pv[p], exp_car[p], exp_cass[p], exp_cass[p]};
        ov = {obs_edge[p], obs_pv[p], obs_car[p], obs_cass[p], obs_led[p]};
        n_checks++;
        if (ov !== ev) begin
          n_fail++;
          $display("FAIL random r=%0d t=%0d edge/pv/car/cass/led got %b expected %b", r, p, ov, ev);
        end
        if (exp_pv[p]) begin
          n_checks++;
          if (obs_per[p] !== 16'(exp_per[p])) begin
            n_fail++;
            $display("FAIL random_period r=%0d t=%0d got %0d expected %0d", r, p, obs_per[p], exp_per[p]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] ev, ov;
    go_idle();
    alt_segs(4, 40, 40);
    play();
    n_checks++;
    if (obs_car[exp_t-1] !== exp_car[exp_t-1]) begin
      n_fail++;
      $display("FAIL rst_prelock got carrier=%b expected %b", obs_car[exp_t-1], exp_car[exp_t-1]);
    end
    ADC_BIT = ~cur_filt;
    repeat (20) tick();
    #2;
    RESET_N = 1'b0;
    #1;
    n_checks++;
    if ({CASS_IN, EDGE, PERIOD_VALID, CARRIER, LED, state_dbg} !== 7'b0 || PERIOD !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs got flags=%b state=%0d period=%0d expected 0",
               {CASS_IN, EDGE, PERIOD_VALID, CARRIER, LED}, state_dbg, PERIOD);
    end
    n_checks++;
    if ({cass8, edge8, pv8, car8, led8, state8} !== 7'b0 || per8 !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs8 got flags=%b state=%0d period=%0d expected 0",
               {cass8, edge8, pv8, car8, led8}, state8, per8);
    end
    ADC_BIT = 1'b0;
    tick(); tick();
    RESET_N = 1'b1;
    repeat (4) tick();
    cur_filt = 1'b0;
    alt_segs(4, 40, 40);
    play();
    for (int p = 0; p < exp_t; p++) begin
      ev = {exp_edge[p], exp_pv[p], exp_car[p], exp_cass[p], exp_cass[p]};
      ov = {obs_edge[p], obs_pv[p], obs_car[p], obs_cass[p], obs_led[p]};
      n_checks++;
      if (ov !== ev) begin
        n_fail++;
        $display("FAIL rst_relock t=%0d edge/pv/car/cass/led got %b expected %b", p, ov, ev);
      end
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_glitch();
    test_lock();
    test_timeout();
    test_abort();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
